// File: rtl/sb_param_shadow.sv
// rtl/sb_param_shadow.sv - switch-block routing muxes with shadowed serial configuration chain
//
// A serial configuration chain (ccff_head -> sreg -> ccff_tail) is loaded in the
// background while a separate active register drives the routing muxes. A commit
// copies the chain into the active register only when exactly L bits were shifted
// since the last commit or reset; any other commit is rejected and flagged.
//
// Ports:
//    prog_clk    configuration clock, the only clock
//    pReset      synchronous active-high reset
//    ccff_head   serial configuration data in
//    ccff_en     shift enable
//    cfg_commit  copy shift register into active register (if length is exact)
//    in_bus      routing inputs: chanx_right, chany_bottom, chanx_left, pins (LSB first)
//    out_bus     routing outputs: right, bottom, left (LSB first)
//    ccff_tail   serial data out (last chain bit)
//    cfg_count   bits shifted since last commit/reset, saturating at L+1
//    cfg_valid   active configuration is loaded
//    cfg_err     sticky: a commit was rejected
module sb_param_shadow #(
   parameter int CHAN_W   = 5,
   parameter int NUM_PIN  = 6,
   parameter int MUX_SIZE = 4,
   parameter int STRIDE   = 1,
   parameter int SKIP     = 5,
   localparam int NUM_IN  = 3*CHAN_W + NUM_PIN,
   localparam int NUM_OUT = 3*CHAN_W,
   localparam int SEL_W   = $clog2(MUX_SIZE),
   localparam int L       = NUM_OUT*SEL_W,
   localparam int CNT_W   = $clog2(L+2)
) (
   input  logic               prog_clk,
   input  logic               pReset,
   input  logic               ccff_head,
   input  logic               ccff_en,
   input  logic               cfg_commit,
   input  logic [NUM_IN-1:0]  in_bus,
   output logic [NUM_OUT-1:0] out_bus,
   output logic               ccff_tail,
   output logic [CNT_W-1:0]   cfg_count,
   output logic               cfg_valid,
   output logic               cfg_err
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_L   = CNT_W'(L);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(L+1);

   logic [L-1:0] sreg;
   logic [L-1:0] active;

   assign ccff_tail = sreg[L-1];

   always_ff @(posedge prog_clk) begin
      if (pReset) begin
         sreg      <= '0;
         active    <= '0;
         cfg_count <= '0;
         cfg_valid <= 1'b0;
         cfg_err   <= 1'b0;
      end else begin
         if (ccff_en) begin
            sreg <= {sreg[L-2:0], ccff_head};
         end
         if (cfg_commit) begin
            // Commit samples the pre-shift chain; a concurrent shift starts the next load at 1.
            if (cfg_count == CNT_L) begin
               active    <= sreg;
               cfg_valid <= 1'b1;
            end else begin
               cfg_err <= 1'b1;
            end
            cfg_count <= ccff_en ? CNT_ONE : '0;
         end else if (ccff_en && (cfg_count != CNT_MAX)) begin
            // L+1 marks an over-length load, which can never be committed.
            cfg_count <= cfg_count + CNT_ONE;
         end
      end
   end

   // Candidate tables are padded to 2**SEL_W entries; unused codes select a constant 0.
   for (genvar j = 0; j < NUM_OUT; j++) begin : g_mux
      logic [(1<<SEL_W)-1:0] cand;
      for (genvar k = 0; k < (1<<SEL_W); k++) begin : g_cand
         if (k < MUX_SIZE) begin : g_used
            localparam int IDX = (j*STRIDE + k*SKIP) % NUM_IN;
            assign cand[k] = in_bus[IDX];
         end else begin : g_unused
            assign cand[k] = 1'b0;
         end
      end
      assign out_bus[j] = cfg_valid & cand[active[j*SEL_W +: SEL_W]];
   end

endmodule

// File: tb/tb_sb_param_shadow.sv
// tb/tb_sb_param_shadow.sv - self-checking bench for sb_param_shadow (MUX_SIZE 4 and 3)
module tb_sb_param_shadow;

   localparam int CHAN_W  = 5;
   localparam int NUM_PIN = 6;
   localparam int STRIDE  = 1;
   localparam int SKIP    = 5;
   localparam int NUM_IN  = 3*CHAN_W + NUM_PIN;
   localparam int NUM_OUT = 3*CHAN_W;
   localparam int L       = NUM_OUT*2;
   localparam int CNT_W   = $clog2(L+2);

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst = 1'b1, head = 1'b0, en = 1'b0, commit = 1'b0;
   logic [NUM_IN-1:0]  in_bus = '0;
   logic [NUM_OUT-1:0] out_a, out_b;
   logic               tail_a, tail_b, valid_a, valid_b, err_a, err_b;
   logic [CNT_W-1:0]   cnt_a, cnt_b;

   sb_param_shadow dut_a (
      .prog_clk(clk), .pReset(rst), .ccff_head(head), .ccff_en(en), .cfg_commit(commit),
      .in_bus(in_bus), .out_bus(out_a), .ccff_tail(tail_a), .cfg_count(cnt_a),
      .cfg_valid(valid_a), .cfg_err(err_a));

   sb_param_shadow #(.MUX_SIZE(3)) dut_b (
      .prog_clk(clk), .pReset(rst), .ccff_head(head), .ccff_en(en), .cfg_commit(commit),
      .in_bus(in_bus), .out_bus(out_b), .ccff_tail(tail_b), .cfg_count(cnt_b),
      .cfg_valid(valid_b), .cfg_err(err_b));

   int n_chk = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Reference model: history of shifted bits (newest first), commit bookkeeping
   bit hist[$];
   int m_cnt = 0;
   bit m_valid = 1'b0, m_err = 1'b0;
   int act_sel[NUM_OUT];

   function automatic bit sbit(int i);
      return (i < hist.size()) ? hist[i] : 1'b0;
   endfunction

   function automatic logic [NUM_OUT-1:0] exp_out(int ms, logic [NUM_IN-1:0] inb);
      logic [NUM_OUT-1:0] r;
      r = '0;
      for (int j = 0; j < NUM_OUT; j++)
         if (m_valid && act_sel[j] < ms)
            r[j] = inb[(j*STRIDE + act_sel[j]*SKIP) % NUM_IN];
      return r;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         hist.delete();
         m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
         for (int j = 0; j < NUM_OUT; j++) act_sel[j] = 0;
      end else begin
         if (commit) begin
            if (m_cnt == L) begin
               for (int j = 0; j < NUM_OUT; j++) act_sel[j] = 2*sbit(2*j+1) + sbit(2*j);
               m_valid = 1'b1;
            end else begin
               m_err = 1'b1;
            end
         end
         if (en) begin
            hist.push_front(head);
            if (hist.size() > L) void'(hist.pop_back());
         end
         if (commit) m_cnt = en ? 1 : 0;
         else if (en && m_cnt < L+1) m_cnt = m_cnt + 1;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("out_bus_ms4", out_a, exp_out(4, in_bus));
         check("out_bus_ms3", out_b, exp_out(3, in_bus));
         check("ccff_tail", {tail_a, tail_b}, {sbit(L-1), sbit(L-1)});
         check("cfg_count", {cnt_a, cnt_b}, {CNT_W'(m_cnt), CNT_W'(m_cnt)});
         check("cfg_valid", {valid_a, valid_b}, {m_valid, m_valid});
         check("cfg_err", {err_a, err_b}, {m_err, m_err});
      end
   end

   function automatic logic [NUM_IN-1:0] rnd_in();
      return NUM_IN'($urandom());
   endfunction

   task automatic step(input bit r, input bit h, input bit e, input bit c, input logic [NUM_IN-1:0] inb);
      rst = r; head = h; en = e; commit = c; in_bus = inb;
      @(posedge clk);
      #2;
   endtask

   task automatic load(input logic [L-1:0] v);
      for (int i = 0; i < L; i++) step(0, v[L-1-i], 1, 0, rnd_in());
   endtask

   logic [L-1:0]       v;
   logic [NUM_IN-1:0]  r;
   logic [NUM_OUT-1:0] e1;

   initial begin
      @(posedge clk);
      #2;
      step(1, 0, 1, 1, rnd_in());
      chk_en = 1'b1;
      check("reset_status", {cnt_a, valid_a, err_a, tail_a}, 0);
      check("reset_out", out_a, 0);

      // Full load: mux 0 sel=2, all others sel=0
      load(L'(2));
      step(0, 0, 0, 1, rnd_in());
      check("full_valid", valid_a, 1);
      check("full_count", cnt_a, 0);
      for (int t = 0; t < 3; t++) begin
         r = rnd_in();
         step(0, 0, 0, 0, r);
         check("full_out_ms4", out_a, {r[14:1], r[10]});
         check("full_out_ms3", out_b, {r[14:1], r[10]});
      end

      // Short load
      step(1, 0, 0, 0, rnd_in());
      for (int i = 0; i < L-1; i++) step(0, 1'($urandom()), 1, 0, rnd_in());
      step(0, 0, 0, 1, '1);
      check("short_status", {err_a, valid_a, cnt_a}, {1'b1, 1'b0, CNT_W'(0)});
      check("short_out", out_a, 0);

      // Simultaneous commit+shift, then shadow update while in_bus toggles
      step(1, 0, 0, 0, rnd_in());
      v = L'({$urandom(), $urandom()});
      load(v);
      step(0, 1'($urandom()), 1, 1, '1);
      check("simul_count", cnt_a, 1);
      for (int j = 0; j < NUM_OUT; j++) e1[j] = (v[2*j +: 2] != 2'd3);
      check("simul_preshift_ms3", out_b, e1);
      for (int i = 0; i < L-1; i++) step(0, 1'($urandom()), 1, 0, rnd_in());
      check("shadow_count", cnt_a, L);
      step(0, 0, 0, 1, rnd_in());
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, rnd_in());

      // Chain delay, saturation, reset mid-stream with priority
      step(1, 0, 0, 0, rnd_in());
      step(0, 1, 1, 0, rnd_in());
      for (int i = 0; i < L-1; i++) step(0, 0, 1, 0, rnd_in());
      check("chain_tail_first_bit", tail_a, 1);
      step(0, 0, 1, 0, rnd_in());
      check("chain_saturate", cnt_a, L+1);
      check("chain_tail_second", tail_a, 0);
      step(0, 0, 1, 0, rnd_in());
      check("chain_sat_hold", cnt_a, L+1);
      step(0, 0, 0, 1, rnd_in());
      check("overlen_err", {err_a, cnt_a}, {1'b1, CNT_W'(0)});
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, rnd_in());
      step(1, 1, 1, 1, '1);
      check("midreset_status", {cnt_a, valid_a, err_a, tail_a}, 0);
      check("midreset_out", out_a, 0);
      step(0, 0, 0, 1, '1);
      check("reload_needed", {err_a, valid_a}, 2'b10);

      // Unused code: every sel=3
      step(1, 0, 0, 0, rnd_in());
      load('1);
      step(0, 0, 0, 1, rnd_in());
      for (int t = 0; t < 3; t++) begin
         r = rnd_in();
         step(0, 0, 0, 0, r);
         check("unused_ms3", out_b, 0);
         for (int j = 0; j < NUM_OUT; j++) e1[j] = r[(j+15) % NUM_IN];
         check("sel3_ms4", out_a, e1);
      end

      // Randomised traffic, commits biased toward the exact-length point
      for (int i = 0; i < 2500; i++) begin
         bit c;
         c = (m_cnt == L) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0);
         step($urandom_range(0, 299) == 0, 1'($urandom()), $urandom_range(0, 3) != 0, c, rnd_in());
      end

      chk_en = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
